muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for the RV32M ops that control_unit decodes to alu_ctrl:
//  OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU.
//  Sits in the execute stage beside the ALU and stalls the pipeline until the result is ready.
//  Runs a registered multiplier and a 1-bit/cycle restoring divider.
// PARAMETERS
//  XLEN     32  operand/result width
//  MUL_LAT  1   cycles spent in MUL state (product register stages), >=1
// PORTS
//  clk_i     in   1     core clock, single clock domain
//  rst_i     in   1     synchronous, active-high reset
//  start_i   in   1     EX holds a valid M-extension op (alu_ctrl is one of the eight above)
//  op_i      in   alu_op_e  operation (ctrl_o.alu_ctrl)
//  rs1_i     in   XLEN  dividend / multiplicand
//  rs2_i     in   XLEN  divisor / multiplier
//  flush_i   in   1     kill the in-flight op (trap or branch mispredict)
//  stall_o   out  1     hold IF/ID/EX; combinational
//  valid_o   out  1     result_o valid, one-cycle pulse
//  result_o  out  XLEN  result of the op
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all operand regs=0, valid_o=0, result_o=0, stall_o=0.
//  States:
//   IDLE -> MUL when start_i and op is a MUL op.
//   IDLE -> DIV when start_i and op is a DIV/REM op with a normal case.
//   IDLE -> DONE when start_i and op is DIV/REM with a special case.
//   MUL -> DONE after MUL_LAT cycles.
//   DIV -> DONE after XLEN iterations.
//   DONE -> IDLE unconditionally.
//  IDLE, on start: latch op, rs1, rs2, sign flags, and |magnitudes| for division.
//  stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV. stall_o is 0 in DONE.
//  start_i is ignored outside IDLE. This includes DONE, so the op still in EX during DONE
//   is not re-issued.
//  Latency from the start cycle T:
//   MUL op: valid_o at T+MUL_LAT+1.
//   DIV normal: valid_o at T+XLEN+1 (T+33 for XLEN=32).
//   DIV special: valid_o at T+1.
//  MUL arithmetic:
//   Form 33x33 signed operands (sign-extend for signed operands, zero-extend for unsigned).
//   Compute a 66-bit product.
//   MUL returns [31:0]. MULH, MULHSU and MULHU return [63:32].
//  DIV arithmetic:
//   Restoring division on magnitudes; 5-bit counter (log2 XLEN).
//   Per cycle: rem = {rem,quo[msb]} - divisor when the difference is non-negative; shift the quotient bit in.
//  Sign fix is combinational in DONE:
//   quotient negated when the operand signs differ (signed ops);
//   remainder takes the dividend's sign.
//  Special cases, decided in IDLE:
//   divisor==0: quotient = all-ones; remainder = rs1.
//   DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
//  valid_o=1 only in DONE. result_o is held until the next DONE.
//  flush_i:
//   In any state, next state is IDLE and valid_o stays 0 for the killed op.
//   flush_i wins over start_i in the same cycle.
//  Reset during an op: same as flush, and state and regs take their reset values.
//  No exceptions are raised: division by zero and overflow are architectural results.
// STRUCTURE
//  tcore_param package:
//   add muldiv_state_e {MD_IDLE, MD_MUL, MD_DIV, MD_DONE};
//   add localparam MD_CNT_W = $clog2(XLEN);
//   reuse the existing alu_op_e encodings.
//  Sub-module serial_divider (iteration datapath):
//   inputs: load, step, dividend, divisor;
//   outputs: quotient, remainder.
//  The sequencer keeps the FSM, the special-case detection, the multiplier and the sign fix.
// TESTING
//  OP_MUL 7 x -3 -> valid_o at T+2, result_o=0xFFFFFFEB; stall_o high for cycles T..T+1.
//  OP_MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  OP_MULH same operands -> 0x00000000.
//  OP_MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
//  OP_DIV -20 / 3 -> valid_o at T+33, quotient 0xFFFFFFFA.
//  OP_REM -20 / 3 -> remainder 0xFFFFFFFE.
//  OP_DIVU 100 / 7 -> 14.
//  OP_REMU 100 / 7 -> 2.
//  OP_DIVU x/0 -> 0xFFFFFFFF at T+1.
//  OP_REM 5/0 -> 5 at T+1.
//  OP_DIV 0x80000000 / -1 -> 0x80000000.
//  OP_REM 0x80000000 / -1 -> 0.
//  flush_i at T+10 of a DIV -> IDLE next cycle; no valid_o pulse.
//   Then a new OP_MUL 2x3 -> 6, correct result with no state left from the killed op.
//  start_i held high through DONE -> exactly one valid_o pulse.
//   Back-to-back DIVU ops issued on consecutive IDLE cycles -> both results correct.
//  rst_i asserted mid-DIV -> all outputs 0 next cycle; the following op computes normally.

Source files
------------

// File: rtl/tcore_param.sv
`default_nettype none
// ============================================================================
// Package  : tcore_param
// Brief    : Shared core encodings: ALU operations and M-extension sequencer
//            state.
// Revision : 1.0
// ============================================================================
package tcore_param;

    localparam int CORE_XLEN = 32;
    localparam int MD_CNT_W  = $clog2(CORE_XLEN);

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_mul_op(alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_divider.sv
`default_nettype none
// ============================================================================
// Module   : serial_divider
// Brief    : Restoring unsigned divider datapath, one quotient bit per step.
// Revision : 1.0
// ============================================================================
module serial_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;

    // Dividend bits shift out of the quotient register's top as quotient bits shift in.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (load) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dvs <= divisor;
        end else if (step) begin
            if (!w_diff[XLEN]) begin
                r_rem <= w_diff[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Multi-cycle RV32M sequencer: registered multiplier plus serial
//            restoring divider, stalling EX until the result is ready.
// Revision : 1.0
// ============================================================================
module muldiv_sequencer
    import tcore_param::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int                 c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(XLEN - 1);
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_LAT - 1);

    muldiv_state_e      r_state;
    muldiv_state_e      w_next;
    logic [c_cnt_w-1:0] r_cnt;
    alu_op_e            r_op;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_special;
    logic [XLEN-1:0]    r_spec_res;
    logic [XLEN-1:0]    r_res_hold;
    logic [2*XLEN-1:0]  r_prod;

    logic               w_is_mul, w_is_div, w_is_rem, w_sdiv;
    logic               w_div0, w_ovf, w_special, w_accept, w_load, w_step;
    logic               w_a_sgn, w_b_sgn;
    logic [XLEN-1:0]    w_abs1, w_abs2, w_spec_res;
    logic [XLEN-1:0]    w_quo, w_rem, w_quo_fix, w_rem_fix, w_res;
    logic [2*XLEN-1:0]  w_ma, w_mb;

    // Issue-side decode, only meaningful while IDLE
    assign w_is_mul   = is_mul_op(op_i);
    assign w_is_div   = is_div_op(op_i);
    assign w_is_rem   = (op_i == OP_REM) || (op_i == OP_REMU);
    assign w_sdiv     = (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_div0     = (rs2_i == '0);
    assign w_ovf      = w_sdiv && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);
    assign w_special  = w_div0 || w_ovf;
    assign w_spec_res = w_div0 ? (w_is_rem ? rs1_i : '1) : (w_is_rem ? '0 : rs1_i);
    assign w_abs1     = (w_sdiv && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign w_abs2     = (w_sdiv && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
    assign w_accept   = (r_state == MD_IDLE) && start_i && !flush_i && (w_is_mul || w_is_div);
    assign w_load     = w_accept && w_is_div && !w_special;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= MD_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: if (w_accept) w_next = w_is_mul ? MD_MUL : (w_special ? MD_DONE : MD_DIV);
                MD_MUL:  if (r_cnt == c_mul_last) w_next = MD_DONE;
                MD_DIV:  if (r_cnt == c_div_last) w_next = MD_DONE;
                default: w_next = MD_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        valid_o = 1'b0;
        w_step  = 1'b0;
        case (r_state)
            MD_IDLE: stall_o = start_i && !flush_i;
            MD_MUL:  stall_o = 1'b1;
            MD_DIV:  begin stall_o = 1'b1; w_step = 1'b1; end
            default: valid_o = !flush_i;
        endcase
    end

    // Low 2*XLEN bits of the 33x33 signed product; extension to 2*XLEN yields the same bits.
    assign w_a_sgn = (r_op == OP_MUL) || (r_op == OP_MULH) || (r_op == OP_MULHSU);
    assign w_b_sgn = (r_op == OP_MUL) || (r_op == OP_MULH);
    assign w_ma    = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
    assign w_mb    = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_op       <= alu_op_e'('0);
            r_a        <= '0;
            r_b        <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_res_hold <= '0;
            r_prod     <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= op_i;
                r_a        <= rs1_i;
                r_b        <= rs2_i;
                r_neg_q    <= w_sdiv && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                r_neg_r    <= w_sdiv && rs1_i[XLEN-1];
                r_special  <= w_is_div && w_special;
                r_spec_res <= w_spec_res;
            end
            if (!flush_i && (((r_state == MD_MUL) && (r_cnt != c_mul_last)) ||
                             ((r_state == MD_DIV) && (r_cnt != c_div_last))))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (r_state == MD_MUL) r_prod <= w_ma * w_mb;
            if ((r_state == MD_DONE) && !flush_i) r_res_hold <= w_res;
        end
    end

    serial_divider #(.XLEN(XLEN)) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (w_load),
        .step      (w_step),
        .dividend  (w_abs1),
        .divisor   (w_abs2),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
    assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

    always_comb begin
        w_res = '0;
        case (r_op)
            OP_MUL:                       w_res = r_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_res = r_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_res = r_special ? r_spec_res : w_quo_fix;
            OP_REM, OP_REMU:              w_res = r_special ? r_spec_res : w_rem_fix;
            default:                      w_res = '0;
        endcase
    end

    assign result_o = (r_state == MD_DONE) ? w_res : r_res_hold;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Self-checking bench for muldiv_sequencer against an arithmetic
//            reference model with a per-cycle expectation schedule.
// Revision : 1.0
// ============================================================================
module tb_muldiv_sequencer;
    import tcore_param::*;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 1;
    localparam int NCYC    = 16384;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    alu_op_e     op;
    logic [31:0] rs1, rs2;
    logic        stall, valid;
    logic [31:0] result;

    muldiv_sequencer #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .flush_i  (flush),
        .stall_o  (stall),
        .valid_o  (valid),
        .result_o (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          exp_stall [NCYC];
    bit          exp_valid [NCYC];
    bit          exp_clr   [NCYC];
    logic [31:0] exp_res   [NCYC];
    logic [31:0] held = '0;
    bit          running = 1'b1;
    int          total = 0;
    int          bad = 0;

    alu_op_e m_ops [8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    function automatic logic [31:0] ref_result(input alu_op_e o, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        bit              ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
            OP_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            OP_MULHSU: begin p = longint'($signed(a)) * longint'({32'b0, b}); return p[63:32]; end
            OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            OP_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input alu_op_e o, input logic [31:0] a, input logic [31:0] b);
        if (o == OP_MUL || o == OP_MULH || o == OP_MULHSU || o == OP_MULHU) return MUL_LAT + 1;
        if (b == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = $urandom_range(0, 15);
            5: begin v = $urandom_range(1, 15); v = -v; end
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Per-cycle compare against the expectation schedule
    always @(negedge clk) begin
        if (running && cyc >= 1) begin
            if (cyc >= NCYC) begin
                $display("FAIL cycle_budget cycle=%0d got=over want=under %0d", cyc, NCYC);
                $fatal(1, "cycle budget exceeded");
            end
            if (exp_clr[cyc]) held = '0;
            check("stall", {31'b0, stall}, {31'b0, exp_stall[cyc]});
            check("valid", {31'b0, valid}, {31'b0, exp_valid[cyc]});
            check("result", result, exp_valid[cyc] ? exp_res[cyc] : held);
            if (exp_valid[cyc]) held = exp_res[cyc];
        end
    end

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Issue one op at the current cycle; hold keeps start/operands up through DONE like a stalled EX.
    task automatic issue(input alu_op_e o, input logic [31:0] a, input logic [31:0] b, input bit hold);
        int t, lat;
        t   = cyc;
        lat = ref_lat(o, a, b);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        for (int k = 0; k < lat; k++) exp_stall[t + k] = 1'b1;
        exp_valid[t + lat] = 1'b1;
        exp_res[t + lat]   = ref_result(o, a, b);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (!hold) begin
                start = 1'b0;
                op    = m_ops[$urandom_range(0, 7)];
                rs1   = $urandom();
                rs2   = $urandom();
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pin(input string name, input alu_op_e o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want);
        check(name, ref_result(o, a, b), want);
    endtask

    initial begin
        #(NCYC * 10 - 50);
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MUL; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        pin("pin_mul",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        pin("pin_mulhu",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        pin("pin_mulh",   OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        pin("pin_mulhsu", OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        pin("pin_div",    OP_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA);
        pin("pin_rem",    OP_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE);
        pin("pin_divu",   OP_DIVU,   32'd100,        32'd7,         32'd14);
        pin("pin_remu",   OP_REMU,   32'd100,        32'd7,         32'd2);
        pin("pin_divu0",  OP_DIVU,   32'h1234_5678,  32'd0,         32'hFFFF_FFFF);
        pin("pin_rem0",   OP_REM,    32'd5,          32'd0,         32'd5);
        pin("pin_divovf", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        pin("pin_removf", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
        check("lat_mul",  32'(ref_lat(OP_MUL, 32'd7, 32'hFFFF_FFFD)), 32'd2);
        check("lat_div",  32'(ref_lat(OP_DIV, 32'hFFFF_FFEC, 32'd3)), 32'd33);
        check("lat_div0", 32'(ref_lat(OP_DIVU, 32'd9, 32'd0)), 32'd1);

        issue(OP_MUL,    32'd7,         32'hFFFF_FFFD, 1'b0);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle(1);
        issue(OP_DIV,    32'hFFFF_FFEC, 32'd3,         1'b1);
        issue(OP_REM,    32'hFFFF_FFEC, 32'd3,         1'b0);
        issue(OP_DIVU,   32'd100,       32'd7,         1'b1);
        issue(OP_REMU,   32'd100,       32'd7,         1'b1);
        issue(OP_DIVU,   32'hDEAD_BEEF, 32'd0,         1'b1);
        issue(OP_REM,    32'd5,         32'd0,         1'b0);
        issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(2);

        // Flush ten cycles into a division, then a fresh multiply
        t = cyc;
        start = 1'b1; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
        for (int k = 0; k <= 10; k++) exp_stall[t + k] = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        idle(1);
        issue(OP_MUL, 32'd2, 32'd3, 1'b1);

        // Back-to-back divides on consecutive IDLE cycles
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b1);
        issue(OP_DIVU, 32'd12345,     32'd11, 1'b1);
        idle(1);

        // Reset in the middle of a division
        t = cyc;
        start = 1'b1; op = OP_DIV; rs1 = 32'hFFFF_FF00; rs2 = 32'd7;
        for (int k = 0; k <= 5; k++) exp_stall[t + k] = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b0;
        exp_clr[t + 6] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);

        for (int n = 0; n < 120; n++) begin
            issue(m_ops[$urandom_range(0, 7)], rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        idle(3);
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
